// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit:
// funct3 encodings, sequencer state encoding and the default data width.
package muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath on unsigned magnitudes.
// acc layout (2*XLEN+1 bits):
//   multiply: {carry/hi word, product low bits / remaining multiplier}, shifted right
//   divide  : {spare bit, partial remainder, dividend/quotient}, shifted left
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [2*XLEN:0] acc,
   input  logic [XLEN-1:0] operand,
   input  logic            mode,      // 0: shift-add multiply, 1: restoring divide
   output logic [2*XLEN:0] acc_next
);

   logic [XLEN:0]   sum_s;
   logic [XLEN:0]   rem_sh_s;
   logic [XLEN-1:0] quot_sh_s;
   logic [XLEN+1:0] diff_s;

   // Single shift-add or shift-subtract step selected by mode
   always_comb begin
      sum_s     = {(XLEN+1){1'b0}};
      rem_sh_s  = {(XLEN+1){1'b0}};
      quot_sh_s = {XLEN{1'b0}};
      diff_s    = {(XLEN+2){1'b0}};
      acc_next  = acc;
      if (mode == 1'b0) begin
         // Add multiplicand into the high half when the current multiplier bit is set,
         // then shift the whole accumulator right one place (carry enters the top).
         sum_s    = acc[2*XLEN:XLEN] + {1'b0, (operand & {XLEN{acc[0]}})};
         acc_next = {1'b0, sum_s, acc[XLEN-1:1]};
      end else begin
         // Shift remainder:quotient left, try subtracting the divisor from the remainder.
         rem_sh_s  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
         quot_sh_s = {acc[XLEN-2:0], 1'b0};
         diff_s    = {1'b0, rem_sh_s} - {2'b00, operand};
         if (diff_s[XLEN+1] == 1'b0) begin
            acc_next = {diff_s[XLEN:0], quot_sh_s[XLEN-1:1], 1'b1};
         end else begin
            acc_next = {rem_sh_s, quot_sh_s};
         end
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage. One bit per cycle,
// sign fix in a dedicated cycle, one-cycle done pulse with a registered result.
// Optional build macro MULDIV_RESULT_CACHE_EN: remember the last completed
// {funct3, rs1, rs2, result} and answer an identical request without iterating.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int              CW       = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);

   state_t          state_r, state_nx_s;
   logic [CW-1:0]   count_r;
   logic [2:0]      f3_r;
   logic            neg_r;
   logic [2*XLEN:0] acc_r, acc_nx_s;
   logic [XLEN-1:0] opnd_r;
   logic [XLEN-1:0] result_r;

   logic            accept_s, is_div_s, sign_a_s, sign_b_s, a_neg_s, b_neg_s;
   logic            div_zero_s, ovf_s, special_s, res_neg_s;
   logic [XLEN-1:0] abs_a_s, abs_b_s, special_res_s;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0] quot_s, rem_s, fix_res_s;
   logic            hit_s;
   logic [XLEN-1:0] cache_res_s;

   assign accept_s = (state_r == IDLE) & start & ~flush;

   // Decode the incoming op: operand signedness, magnitudes and special cases
   always_comb begin
      is_div_s = funct3[2];
      case (funct3)
         F3_MULH:   begin sign_a_s = 1'b1; sign_b_s = 1'b1; end
         F3_MULHSU: begin sign_a_s = 1'b1; sign_b_s = 1'b0; end
         F3_DIV:    begin sign_a_s = 1'b1; sign_b_s = 1'b1; end
         F3_REM:    begin sign_a_s = 1'b1; sign_b_s = 1'b1; end
         default:   begin sign_a_s = 1'b0; sign_b_s = 1'b0; end
      endcase
      a_neg_s = sign_a_s & rs1[XLEN-1];
      b_neg_s = sign_b_s & rs2[XLEN-1];
      abs_a_s = a_neg_s ? -rs1 : rs1;
      abs_b_s = b_neg_s ? -rs2 : rs2;
      // Remainder follows the dividend sign; everything else is sign(a) xor sign(b).
      if (funct3 == F3_REM) begin
         res_neg_s = a_neg_s;
      end else begin
         res_neg_s = a_neg_s ^ b_neg_s;
      end
      div_zero_s = is_div_s & (rs2 == ZERO);
      ovf_s      = ((funct3 == F3_DIV) | (funct3 == F3_REM)) & (rs1 == MIN_NEG) & (rs2 == ALL_ONES);
      special_s  = div_zero_s | ovf_s;
      if (div_zero_s) begin
         special_res_s = funct3[1] ? rs1 : ALL_ONES;
      end else if (ovf_s) begin
         special_res_s = funct3[1] ? ZERO : MIN_NEG;
      end else begin
         special_res_s = ZERO;
      end
   end

   // Sign correction and word selection applied in the FIX cycle
   always_comb begin
      prod_s = neg_r ? -acc_r[2*XLEN-1:0] : acc_r[2*XLEN-1:0];
      quot_s = neg_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
      rem_s  = neg_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
      case (f3_r)
         F3_MUL:    fix_res_s = prod_s[XLEN-1:0];
         F3_MULH,
         F3_MULHSU,
         F3_MULHU:  fix_res_s = prod_s[2*XLEN-1:XLEN];
         F3_DIV,
         F3_DIVU:   fix_res_s = quot_s;
         F3_REM,
         F3_REMU:   fix_res_s = rem_s;
         default:   fix_res_s = ZERO;
      endcase
   end

   muldiv_step #(.XLEN(XLEN)) u_step (
      .acc      (acc_r),
      .operand  (opnd_r),
      .mode     (f3_r[2]),
      .acc_next (acc_nx_s)
   );

`ifdef MULDIV_RESULT_CACHE_EN
   logic [XLEN-1:0] op_a_r, op_b_r;
   logic            cache_valid_r;
   logic [2:0]      cache_f3_r;
   logic [XLEN-1:0] cache_a_r, cache_b_r, cache_res_r;

   assign hit_s = accept_s & cache_valid_r & (funct3 == cache_f3_r) &
                  (rs1 == cache_a_r) & (rs2 == cache_b_r);
   assign cache_res_s = cache_res_r;

   // Raw operands of the in-flight op, needed to tag its cached result
   always_ff @(posedge clk) begin
      if (reset) begin
         op_a_r <= ZERO;
         op_b_r <= ZERO;
      end else if (accept_s) begin
         op_a_r <= rs1;
         op_b_r <= rs2;
      end
   end

   // Last-result cache: fill on every completed op, drop on reset or flush
   always_ff @(posedge clk) begin
      if (reset) begin
         cache_valid_r <= 1'b0;
         cache_f3_r    <= 3'b000;
         cache_a_r     <= ZERO;
         cache_b_r     <= ZERO;
         cache_res_r   <= ZERO;
      end else if (flush) begin
         cache_valid_r <= 1'b0;
      end else if (accept_s & special_s) begin
         cache_valid_r <= 1'b1;
         cache_f3_r    <= funct3;
         cache_a_r     <= rs1;
         cache_b_r     <= rs2;
         cache_res_r   <= special_res_s;
      end else if (state_r == FIX) begin
         cache_valid_r <= 1'b1;
         cache_f3_r    <= f3_r;
         cache_a_r     <= op_a_r;
         cache_b_r     <= op_b_r;
         cache_res_r   <= fix_res_s;
      end
   end
`else
   assign hit_s       = 1'b0;
   assign cache_res_s = ZERO;
`endif

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Sequencer next-state: flush kills CALC/FIX, never an already-retiring DONE
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nx_s = (special_s | hit_s) ? DONE : CALC;
            end else begin
               state_nx_s = IDLE;
            end
         end
         CALC: begin
            if (flush) begin
               state_nx_s = IDLE;
            end else if (count_r == LAST_CNT) begin
               state_nx_s = FIX;
            end else begin
               state_nx_s = CALC;
            end
         end
         FIX: begin
            if (flush) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration and result write on entry to DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r  <= {CW{1'b0}};
         f3_r     <= 3'b000;
         neg_r    <= 1'b0;
         acc_r    <= {(2*XLEN+1){1'b0}};
         opnd_r   <= ZERO;
         result_r <= ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  f3_r    <= funct3;
                  neg_r   <= res_neg_s;
                  count_r <= {CW{1'b0}};
                  // Multiply iterates over rs2 bits adding |rs1|; divide shifts |rs1| through.
                  acc_r   <= {1'b0, ZERO, (is_div_s ? abs_a_s : abs_b_s)};
                  opnd_r  <= is_div_s ? abs_b_s : abs_a_s;
                  if (hit_s) begin
                     result_r <= cache_res_s;
                  end else if (special_s) begin
                     result_r <= special_res_s;
                  end
               end
            end
            CALC: begin
               acc_r   <= acc_nx_s;
               count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            end
            FIX: begin
               if (!flush) begin
                  result_r <= fix_res_s;
               end
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end
   end

   assign stall  = accept_s | (state_r == CALC) | (state_r == FIX);
   assign done   = (state_r == DONE);
   assign result = result_r;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit with its own sequencer, sitting beside the ALU in the EX stage. It accepts one M-extension op, holds the pipeline through stall while it iterates one bit per cycle, and returns a registered result with a one-cycle done pulse. Its stall output feeds the hazard/stall logic so IF/ID/EX hold until done.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
start  in  1  EX-stage M-op valid; qualified only in IDLE
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  in  XLEN  operand A (multiplicand/dividend)
rs2  in  XLEN  operand B (multiplier/divisor)
flush  in  1  kill the in-flight op (branch mispredict/trap)
stall  out  1  hold pipeline; combinational
done  out  1  one-cycle pulse; result valid this cycle
result  out  XLEN  registered result; held until the next done

Behaviour:
- Reset: state=IDLE, done=0, result=0, stall=0, counter=0, internal accumulators=0. Reset mid-operation aborts without done.
- States: IDLE, CALC, FIX, DONE.
- IDLE & start: latch funct3 and the absolute values of operands (signedness per funct3; MULHSU treats rs1 as signed, rs2 as unsigned), latch result sign, counter=0.
  - Special cases go directly to DONE the next cycle: div/rem by zero, and signed overflow.
  - Otherwise go to CALC.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter++. After XLEN cycles, go to FIX.
- FIX: apply two's-complement sign correction and select the low word (MUL), high word (MULH*), quotient, or remainder into result. Go to DONE.
- DONE: done=1 for exactly one cycle. Return to IDLE.
- Latency, start at cycle 0: CALC cycles 1..XLEN, FIX at XLEN+1, done at XLEN+2 (34 for XLEN=32). Special cases: done at cycle 1.
- stall = (IDLE & start & ~flush) | CALC | FIX. stall is low during DONE so EX advances on the done cycle.
- start outside IDLE is ignored.
- Division semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Overflow (DIV/REM with rs1=0x80000000, rs2=-1): quotient = 0x80000000; remainder = 0.
- flush in any state other than IDLE: next state IDLE; no done pulse; result unchanged.
- flush together with start in IDLE: start ignored.
- flush during DONE: the done pulse still occurs (op already retired).

Optional Feature:
MULDIV_RESULT_CACHE_EN:
- With the macro defined: the unit keeps {funct3, rs1, rs2, result} of the last completed op. A start with identical inputs goes IDLE->DONE with the cached result (done at cycle 1). The cache is invalidated by reset and by flush.
- Without it: every op iterates fully; no cache registers exist.

Decomposition:
- Package muldiv_pkg: funct3 encoding localparams (F3_MUL..F3_REMU), the state encoding (IDLE/CALC/FIX/DONE), and the XLEN default.
- One sub-module, muldiv_step: combinational single-iteration shift-add / shift-subtract step. It takes {acc, operand, mode} and returns the next acc. The FSM, counter and sign fix stay in ex_muldiv_unit.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done only at cycle 34, stall high cycles 0..33, low at cycle 34.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU 0xFFFFFFFF, 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFEC (-20) / 3 -> 0xFFFFFFFA; REM same -> 0xFFFFFFFE; DIVU 20/3 -> 6.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both done at cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, done at cycle 1.
- Start MUL, assert flush at cycle 10 -> no done, stall low from cycle 11, new DIVU 9/2 started at cycle 11 -> 4 at cycle 45.
- Reset at cycle 20 of a DIV -> state IDLE, result 0, no done. With MULDIV_RESULT_CACHE_EN, repeat a completed MUL 7*-3 -> 0xFFFFFFEB at cycle 1.
